// File: rtl/int2float_pipe.sv
// int2float_pipe: 3-stage integer -> minifloat converter, valid/ready flow.
// Build option: define INT2FLOAT_ROUND_EN for RNE rounding + saturation.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake, in_data = IN_W-bit integer
//   out_valid/out_ready  output handshake
//   out_data             {sign (SIGNED only), exp[EXP_W], man[MAN_W]}
//   out_inexact          nonzero bits were discarded
//   out_ovf              rounding overflowed, result saturated
module int2float_pipe #(
   parameter int IN_W   = 11,
   parameter int EXP_W  = 3,
   parameter int MAN_W  = 4,
   parameter int SIGNED = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [IN_W-1:0]               in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SIGNED+EXP_W+MAN_W-1:0] out_data,
   output logic                          out_inexact,
   output logic                          out_ovf
);

   localparam int OW = SIGNED + EXP_W + MAN_W;
   localparam int PW = $clog2(IN_W);
   localparam int LW = IN_W - MAN_W + 1;

   logic s1_v_q, s2_v_q, out_valid_q;
   logic adv3, ld2, ld1;

   // A stage loads when empty or when its successor loads.
   assign adv3     = !out_valid_q | out_ready;
   assign ld2      = !s2_v_q | adv3;
   assign ld1      = !s1_v_q | ld2;
   assign in_ready = ld1;

   // S1: sign/magnitude and leading-one index
   logic            s1_sign_d, s1_sign_q;
   logic [IN_W-1:0] s1_mag_d, s1_mag_q;
   logic [PW-1:0]   s1_p_d, s1_p_q;

   always_comb begin
      s1_sign_d = 1'b0;
      s1_mag_d  = in_data;
      if (SIGNED != 0 && in_data[IN_W-1]) begin
         s1_sign_d = 1'b1;
         // -2^(IN_W-1) negates to itself, which reads correctly unsigned
         s1_mag_d  = -in_data;
      end
      s1_p_d = '0;
      for (int i = 0; i < IN_W; i++)
         if (s1_mag_d[i]) s1_p_d = PW'(i);
   end

   // S2: normalise, split mantissa / guard / sticky
   logic [IN_W-1:0]  norm;
   logic [LW-1:0]    low;
   logic             s2_sign_q;
   logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
   logic [MAN_W-1:0] s2_man_d, s2_man_q;
   logic             s2_g_d, s2_g_q;
   logic             s2_st_d, s2_st_q;

   always_comb begin
      norm = s1_mag_q << (PW'(IN_W - 1) - s1_p_q);
      // two zero pads keep guard/sticky defined even when IN_W == MAN_W+1
      low  = LW'({norm, 2'b00});
      s2_exp_d = '0;
      s2_man_d = s1_mag_q[MAN_W-1:0];
      s2_g_d   = 1'b0;
      s2_st_d  = 1'b0;
      if (s1_p_q >= PW'(MAN_W)) begin
         s2_exp_d = EXP_W'(s1_p_q - PW'(MAN_W - 1));
         s2_man_d = norm[IN_W-2 -: MAN_W];
         s2_g_d   = low[LW-1];
         s2_st_d  = |low[LW-2:0];
      end
   end

   // S3: round and pack
   logic [EXP_W-1:0] e3;
   logic [MAN_W-1:0] m3;
   logic             ovf_d, inx_d;
   logic [OW-1:0]    data_d;
   logic [OW-1:0]    out_data_q;
   logic             out_inexact_q, out_ovf_q;
`ifdef INT2FLOAT_ROUND_EN
   logic             inc;
   logic [MAN_W:0]   msum;
   logic [EXP_W:0]   esum;
`endif

   always_comb begin
      inx_d = s2_g_q | s2_st_q;
`ifdef INT2FLOAT_ROUND_EN
      inc   = s2_g_q & (s2_st_q | s2_man_q[0]);
      msum  = {1'b0, s2_man_q} + (MAN_W+1)'(inc);
      esum  = {1'b0, s2_exp_q} + (EXP_W+1)'(msum[MAN_W]);
      e3    = esum[EXP_W-1:0];
      m3    = msum[MAN_W-1:0];
      // exp max is all ones, so overflow is exactly the carry-out bit
      ovf_d = esum[EXP_W];
      if (esum[EXP_W]) begin
         e3 = '1;
         m3 = '1;
      end
`else
      e3    = s2_exp_q;
      m3    = s2_man_q;
      ovf_d = 1'b0;
`endif
      data_d = OW'({s2_sign_q, e3, m3});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v_q        <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_mag_q      <= '0;
         s1_p_q        <= '0;
         s2_v_q        <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_exp_q      <= '0;
         s2_man_q      <= '0;
         s2_g_q        <= 1'b0;
         s2_st_q       <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_inexact_q <= 1'b0;
         out_ovf_q     <= 1'b0;
      end else begin
         if (ld1) s1_v_q <= in_valid;
         if (ld1 & in_valid) begin
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            s1_p_q    <= s1_p_d;
         end
         if (ld2) s2_v_q <= s1_v_q;
         if (ld2 & s1_v_q) begin
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s2_exp_d;
            s2_man_q  <= s2_man_d;
            s2_g_q    <= s2_g_d;
            s2_st_q   <= s2_st_d;
         end
         if (adv3) out_valid_q <= s2_v_q;
         if (adv3 & s2_v_q) begin
            out_data_q    <= data_d;
            out_inexact_q <= inx_d;
            out_ovf_q     <= ovf_d;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_inexact = out_inexact_q;
   assign out_ovf     = out_ovf_q;

endmodule

// File: tb/tb_int2float_pipe.sv
// tb_int2float_pipe: random + directed bench with arithmetic reference model.
// Checks an unsigned and a signed instance driven by the same stimulus.
module tb_int2float_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready;
   logic [10:0] in_data;
   logic        in_ready, out_valid, out_inexact, out_ovf;
   logic [6:0]  out_data;
   logic        s_in_ready, s_out_valid, s_out_inexact, s_out_ovf;
   logic [7:0]  s_out_data;

   int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_inexact(out_inexact), .out_ovf(out_ovf));

   int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(1)) u_sgn (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_inexact(s_out_inexact), .out_ovf(s_out_ovf));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [10:0] x;
      logic [9:0]  eu;
      logic [9:0]  es;
      int          acc;
      bit          lat;
   } ent_t;

   ent_t q[$];
   bit lat_chk    = 1'b0;
   bit rst_seen   = 1'b0;
   bit prev_stall = 1'b0;
   bit front_seen = 1'b0;
   int or_mode    = 0;
   int or_idx     = 0;

   logic [10:0] dv [9] = '{11'd0, 11'd13, 11'd16, 11'd100, 11'd280,
                           11'd264, 11'd2047, 11'h7F0, 11'h400};

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Returns {ovf, inexact, data[7:0]}; data = {sign, exp, man} when sgn,
   // else {0, exp, man}. Works on the real value, not on bit fields.
   function automatic logic [9:0] model(input logic [10:0] x, input bit sgn);
      int mag, s, p, sh, base, rem, e, m;
      int half;
      bit inx, ovf;
      logic [9:0] r;
      s   = 0;
      mag = int'(x);
      if (sgn && x[10]) begin
         s   = 1;
         mag = 2048 - int'(x);
      end
      inx = 1'b0;
      ovf = 1'b0;
      if (mag < 16) begin
         e = 0;
         m = mag;
      end else begin
         p = 0;
         while ((mag >> (p + 1)) != 0) p++;
         sh   = p - 4;
         base = mag >> sh;
         rem  = mag - (base << sh);
         inx  = (rem != 0);
`ifdef INT2FLOAT_ROUND_EN
         if (sh > 0) begin
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (base % 2) == 1)) base++;
         end
`else
         half = 0;
`endif
         if (base == 32) begin
            base = 16;
            p++;
         end
         e = p - 3;
         m = base - 16;
         if (e > 7) begin
            e   = 7;
            m   = 15;
            ovf = 1'b1;
         end
      end
      r[9]   = ovf;
      r[8]   = inx;
      r[7]   = sgn ? s[0] : 1'b0;
      r[6:4] = e[2:0];
      r[3:0] = m[3:0];
      return r;
   endfunction

   // out_ready driver, updated 2 time units after each rising edge
   always @(posedge clk) begin
      #2;
      case (or_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = ((or_idx % 4) == 0) || ((or_idx % 4) == 3);
            or_idx++;
         end
         2: out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // compare process
   always @(negedge clk) begin
      ent_t e;
      bit   exp_rdy;
      cyc++;
      if (!rst_n) begin
         q.delete();
         rst_seen   = 1'b1;
         prev_stall = 1'b0;
         front_seen = 1'b0;
      end else begin
         if (rst_seen) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_inexact", out_inexact, 0);
            chk("rst_out_ovf", out_ovf, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_s_out_valid", s_out_valid, 0);
            rst_seen = 1'b0;
         end
         exp_rdy = !(q.size() == 3 && !out_ready);
         chk("in_ready", in_ready, exp_rdy);
         chk("s_in_ready", s_in_ready, exp_rdy);
         if (prev_stall) chk("hold_valid", out_valid, 1);
         if (q.size() == 0) begin
            chk("spurious_valid", out_valid, 0);
            chk("s_spurious_valid", s_out_valid, 0);
         end else if (out_valid) begin
            e = q[0];
            if (!front_seen) begin
               front_seen = 1'b1;
               if (e.lat) chk("latency", cyc - e.acc, 3);
            end
            chk($sformatf("u_data x=%0d", e.x), out_data, e.eu[6:0]);
            chk($sformatf("u_inexact x=%0d", e.x), out_inexact, e.eu[8]);
            chk($sformatf("u_ovf x=%0d", e.x), out_ovf, e.eu[9]);
            chk("s_valid", s_out_valid, 1);
            chk($sformatf("s_data x=%0h", e.x), s_out_data, e.es[7:0]);
            chk($sformatf("s_inexact x=%0h", e.x), s_out_inexact, e.es[8]);
            chk($sformatf("s_ovf x=%0h", e.x), s_out_ovf, e.es[9]);
            if (out_ready) begin
               void'(q.pop_front());
               front_seen = 1'b0;
            end
         end
         prev_stall = out_valid && !out_ready;
         if (in_valid && in_ready) begin
            e.x   = in_data;
            e.eu  = model(in_data, 1'b0);
            e.es  = model(in_data, 1'b1);
            e.acc = cyc;
            e.lat = lat_chk;
            q.push_back(e);
         end
      end
   end

   task automatic send(input logic [10:0] x);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("send_accept", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
      #1;
   endtask

   function automatic logic [10:0] rnd_val();
      if ($urandom_range(0, 3) == 0) return 11'($urandom_range(0, 40));
      return 11'($urandom);
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // pin the model against hand-computed values
      chk("model_0", model(11'd0, 1'b0), 10'h000);
      chk("model_13", model(11'd13, 1'b0), 10'h00D);
      chk("model_16", model(11'd16, 1'b0), 10'h010);
      chk("model_100", model(11'd100, 1'b0), 10'h039);
      chk("model_264", model(11'd264, 1'b0), 10'h150);
`ifdef INT2FLOAT_ROUND_EN
      chk("model_280", model(11'd280, 1'b0), 10'h152);
      chk("model_2047", model(11'd2047, 1'b0), 10'h37F);
`else
      chk("model_280", model(11'd280, 1'b0), 10'h151);
      chk("model_2047", model(11'd2047, 1'b0), 10'h17F);
`endif
      chk("model_m16", model(11'h7F0, 1'b1), 10'h090);
      chk("model_m1024", model(11'h400, 1'b1), 10'h0F0);

      // directed values through an empty pipe, latency checked
      lat_chk = 1'b1;
      foreach (dv[i]) begin
         send(dv[i]);
         idle(4);
      end
      lat_chk = 1'b0;

      // back-to-back throughput
      for (int i = 0; i < 20; i++) send(rnd_val());
      idle(5);

      // backpressure 1,0,0,1
      or_idx  = 0;
      or_mode = 1;
      for (int i = 0; i < 8; i++) send(rnd_val());
      idle(20);
      or_mode = 0;
      drain();

      // random gaps and random backpressure
      or_mode = 2;
      for (int i = 0; i < 300; i++) begin
         send(rnd_val());
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(1);
      or_mode = 0;
      drain();

      // reset with three words stuck in the pipe
      or_mode = 3;
      idle(3);
      send(11'd100);
      send(11'd280);
      send(11'd2047);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      or_mode  = 0;
      idle(2);
      lat_chk = 1'b1;
      send(11'd13);
      idle(6);
      lat_chk = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
